ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- EX-to-MEM pipeline register of the 5-stage RV32I core, directly downstream of the execute ALU and branch comparator.
- Captures the ALU result, branch outcome and store data, and resolves control flow.
- Issues a one-cycle fetch redirect for taken branches and jumps.
- Holds its contents under a MEM-side stall and squashes them on flush.

Parameters:
- DATA_WIDTH, 32, width of data, PC and immediate paths.
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  EX holds a valid instruction.
- in_ready  output  1  stage can accept an instruction this cycle.
- alu_out  input  DATA_WIDTH  ALU result.
- branch_taken  input  1  branch comparator result.
- is_branch  input  1  conditional branch.
- is_jal  input  1  JAL.
- is_jalr  input  1  JALR.
- pc  input  DATA_WIDTH  PC of the EX instruction.
- imm  input  DATA_WIDTH  sign-extended immediate.
- rs1_data  input  DATA_WIDTH  forwarded rs1, used for the JALR target.
- rs2_data  input  DATA_WIDTH  forwarded rs2, used as store data.
- rd  input  REG_ADDR_WIDTH  destination register.
- reg_write, mem_read, mem_write  input  1 each  control bits.
- funct3  input  3  load/store size and sign.
- mem_stall  input  1  MEM cannot accept; hold contents.
- flush  input  1  squash the captured instruction.
- out_valid  output  1  MEM-side valid.
- out_result, out_store_data  output  DATA_WIDTH  registered alu_out and rs2_data.
- out_rd  output  REG_ADDR_WIDTH  registered rd.
- out_reg_write, out_mem_read, out_mem_write  output  1 each  registered control, gated by out_valid.
- out_funct3  output  3  registered funct3.
- redirect_valid  output  1  one-cycle fetch redirect pulse.
- redirect_pc  output  DATA_WIDTH  redirect target.

Behaviour:
- Reset (async, rst=1): every output register clears to 0 and the FSM enters EMPTY.
  - in_ready therefore reads 1 during and after reset.
- Handshake: in_ready = !out_valid || !mem_stall.
  - Capture occurs on a clock edge when in_valid && in_ready && !flush.
  - Latency is 1 cycle from capture to out_valid.
- FSM states: EMPTY, FULL, HELD.
  - EMPTY to FULL on capture.
  - FULL with mem_stall goes to HELD; without mem_stall it goes to FULL on a new capture, else EMPTY.
  - HELD stays HELD while mem_stall is 1. When mem_stall drops it goes to FULL or EMPTY by the same rule as FULL.
  - In HELD, all out_* are frozen and no capture happens; in_ready is 0.
- Flush has priority over capture and stall. The next edge forces EMPTY and out_valid=0, and the output fields keep their values.
- Redirect:
  - take = is_jal || is_jalr || (is_branch && branch_taken), evaluated at capture.
  - Target for branch and JAL: pc+imm.
  - Target for JALR: (rs1_data+imm) with bit 0 cleared.
  - All target arithmetic is modulo 2^DATA_WIDTH; wrap-around is not flagged.
  - redirect_valid and redirect_pc are registered and assert for exactly the one cycle following capture. They never re-assert while HELD.
  - A not-taken branch gives no redirect.
  - Flush in the capture cycle suppresses the redirect.
- Branch rows: out_reg_write=0, out_mem_read=0 and out_mem_write=0 are forced.
- JAL and JALR: out_result takes alu_out as provided, i.e. the link value pc+4 computed by EX.
- Simultaneous cases:
  - mem_stall and in_valid with the stage full: the input is not accepted (in_ready=0).
  - flush and mem_stall together: flush wins.

Optional Feature:
- Macro: EX_MEM_MISALIGN_EN.
- Defined:
  - Adds output exc_valid (1 bit) and exc_cause (2 bits): 0 = instruction-address misaligned, 1 = load misaligned, 2 = store misaligned.
  - A taken target with bits [1:0] != 0 sets cause 0 and suppresses the redirect.
  - A load or store with a halfword at alu_out[0]=1, or a word with alu_out[1:0] != 0, sets cause 1 or 2 and forces the memory controls to 0.
  - exc_valid is registered alongside out_valid and clears on flush and reset.
- Undefined: no such ports exist and no checks are made; the redirect is always issued when take=1.

Test Plan:
- Reset mid-operation: rst pulsed while FULL with out_result=0x1234 -> all outputs 0 immediately without waiting for an edge; in_ready=1.
- Taken BEQ: pc=0x100, imm=0x20, branch_taken=1 -> next cycle redirect_valid=1 and redirect_pc=0x120 for one cycle; out_reg_write=0.
- JALR: rs1_data=0x2003, imm=0x4, alu_out=0x104 -> redirect_pc=0x2006 and out_result=0x104.
- Stall hold: capture alu_out=0xAA, then mem_stall=1 for 3 cycles while the EX inputs change -> out_result stays 0xAA, in_ready=0 and redirect does not repeat; stall drop -> next input captured.
- Flush priority: capture with flush=1 and mem_stall=1 -> out_valid=0 next cycle and no redirect.
- EX_MEM_MISALIGN_EN: word store at alu_out=0x1002 -> exc_valid=1, exc_cause=2, out_mem_write=0.

Source files
------------

// File: rtl/ex_mem_if.sv
// EX-to-MEM stage bundle: EX-side instruction fields, MEM-side hold/squash
// controls, the registered MEM-side outputs and the fetch redirect.
// The exc_valid/exc_cause pair exists only when EX_MEM_MISALIGN_EN is defined.
interface ex_mem_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  // EX side
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     alu_out;
  logic                      branch_taken;
  logic                      is_branch;
  logic                      is_jal;
  logic                      is_jalr;
  logic [DATA_WIDTH-1:0]     pc;
  logic [DATA_WIDTH-1:0]     imm;
  logic [DATA_WIDTH-1:0]     rs1_data;
  logic [DATA_WIDTH-1:0]     rs2_data;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic                      reg_write;
  logic                      mem_read;
  logic                      mem_write;
  logic [2:0]                funct3;

  // Pipeline control
  logic                      mem_stall;
  logic                      flush;

  // MEM side
  logic                      out_valid;
  logic [DATA_WIDTH-1:0]     out_result;
  logic [DATA_WIDTH-1:0]     out_store_data;
  logic [REG_ADDR_WIDTH-1:0] out_rd;
  logic                      out_reg_write;
  logic                      out_mem_read;
  logic                      out_mem_write;
  logic [2:0]                out_funct3;

  // Fetch redirect
  logic                      redirect_valid;
  logic [DATA_WIDTH-1:0]     redirect_pc;

`ifdef EX_MEM_MISALIGN_EN
  logic                      exc_valid;
  logic [1:0]                exc_cause;
`endif

  // Producer of instructions and pipeline controls (EX / hazard unit)
  modport master (
    output in_valid, alu_out, branch_taken, is_branch, is_jal, is_jalr,
    output pc, imm, rs1_data, rs2_data, rd, reg_write, mem_read, mem_write, funct3,
    output mem_stall, flush,
    input  in_ready,
    input  out_valid, out_result, out_store_data, out_rd,
    input  out_reg_write, out_mem_read, out_mem_write, out_funct3,
`ifdef EX_MEM_MISALIGN_EN
    input  exc_valid, exc_cause,
`endif
    input  redirect_valid, redirect_pc
  );

  // The pipeline register itself
  modport slave (
    input  in_valid, alu_out, branch_taken, is_branch, is_jal, is_jalr,
    input  pc, imm, rs1_data, rs2_data, rd, reg_write, mem_read, mem_write, funct3,
    input  mem_stall, flush,
    output in_ready,
    output out_valid, out_result, out_store_data, out_rd,
    output out_reg_write, out_mem_read, out_mem_write, out_funct3,
`ifdef EX_MEM_MISALIGN_EN
    output exc_valid, exc_cause,
`endif
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX-to-MEM pipeline register of the RV32I core.
// Captures ALU result, store data and control, resolves branches/jumps into
// a one-cycle registered fetch redirect, holds under mem_stall and squashes
// on flush (flush beats both capture and stall).
// Optional feature macro: EX_MEM_MISALIGN_EN adds misalignment exceptions
// (exc_valid/exc_cause) for taken targets and load/store addresses.
module ex_mem_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic    clk,
  input  logic    rst,
  ex_mem_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    HELD  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic                      valid_int;
  logic                      in_ready_int;
  logic                      capture;

  logic                      take;
  logic                      redirect_ok;
  logic                      mem_kill;
  logic [DATA_WIDTH-1:0]     pc_target;
  logic [DATA_WIDTH-1:0]     jalr_sum;
  logic [DATA_WIDTH-1:0]     target;

  logic [DATA_WIDTH-1:0]     result_reg;
  logic [DATA_WIDTH-1:0]     store_data_reg;
  logic [REG_ADDR_WIDTH-1:0] rd_reg;
  logic                      reg_write_reg;
  logic                      mem_read_reg;
  logic                      mem_write_reg;
  logic [2:0]                funct3_reg;
  logic                      redirect_valid_reg;
  logic [DATA_WIDTH-1:0]     redirect_pc_reg;

  // Any non-EMPTY state means the MEM side holds a live instruction.
  assign valid_int    = (state_reg != EMPTY);
  assign in_ready_int = !valid_int || !bus.mem_stall;
  assign capture      = bus.in_valid && in_ready_int && !bus.flush;

  // Control-flow resolution; all target arithmetic wraps silently.
  assign take      = bus.is_jal || bus.is_jalr || (bus.is_branch && bus.branch_taken);
  assign pc_target = bus.pc + bus.imm;
  assign jalr_sum  = bus.rs1_data + bus.imm;
  assign target    = bus.is_jalr ? {jalr_sum[DATA_WIDTH-1:1], 1'b0} : pc_target;

`ifdef EX_MEM_MISALIGN_EN
  logic       target_mis;
  logic       access_mis;
  logic       load_mis;
  logic       store_mis;
  logic       exc_det;
  logic [1:0] exc_cause_det;
  logic       exc_valid_reg;
  logic [1:0] exc_cause_reg;

  // Address checks: funct3[1:0] encodes the access size (byte/half/word).
  always_comb begin
    target_mis    = take && (target[1:0] != 2'b00);
    access_mis    = ((bus.funct3[1:0] == 2'b01) && bus.alu_out[0]) ||
                    ((bus.funct3[1:0] == 2'b10) && (bus.alu_out[1:0] != 2'b00));
    load_mis      = bus.mem_read  && !bus.is_branch && access_mis;
    store_mis     = bus.mem_write && !bus.is_branch && access_mis;
    exc_det       = target_mis || load_mis || store_mis;
    exc_cause_det = 2'd2;
    if (target_mis) begin
      exc_cause_det = 2'd0;
    end else if (load_mis) begin
      exc_cause_det = 2'd1;
    end
    redirect_ok   = take && !target_mis;
    mem_kill      = bus.is_branch || load_mis || store_mis;
  end

  // Exception flag travels with the captured instruction; flush drops it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_valid_reg <= 1'b0;
      exc_cause_reg <= 2'd0;
    end else if (bus.flush) begin
      exc_valid_reg <= 1'b0;
    end else if (capture) begin
      exc_valid_reg <= exc_det;
      exc_cause_reg <= exc_cause_det;
    end
  end

  assign bus.exc_valid = exc_valid_reg && valid_int;
  assign bus.exc_cause = exc_cause_reg;
`else
  // Without the misalignment checks only branches suppress memory controls.
  always_comb begin
    redirect_ok = take;
    mem_kill    = bus.is_branch;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: flush first, then stall hold, then capture/drain.
  always_comb begin
    state_next = state_reg;
    if (bus.flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (capture) begin
            state_next = FULL;
          end
        end
        FULL, HELD: begin
          if (bus.mem_stall) begin
            state_next = HELD;
          end else if (capture) begin
            state_next = FULL;
          end else begin
            state_next = EMPTY;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Payload loads only on capture, so it is frozen while held and kept on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_reg     <= '0;
      store_data_reg <= '0;
      rd_reg         <= '0;
      reg_write_reg  <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      funct3_reg     <= 3'd0;
    end else if (capture) begin
      result_reg     <= bus.alu_out;
      store_data_reg <= bus.rs2_data;
      rd_reg         <= bus.rd;
      reg_write_reg  <= bus.reg_write && !bus.is_branch;
      mem_read_reg   <= bus.mem_read  && !mem_kill;
      mem_write_reg  <= bus.mem_write && !mem_kill;
      funct3_reg     <= bus.funct3;
    end
  end

  // Redirect is a pulse: only the edge that captures a taken jump/branch sets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
    end else begin
      redirect_valid_reg <= capture && redirect_ok;
      redirect_pc_reg    <= (capture && redirect_ok) ? target : '0;
    end
  end

  assign bus.in_ready       = in_ready_int;
  assign bus.out_valid      = valid_int;
  assign bus.out_result     = result_reg;
  assign bus.out_store_data = store_data_reg;
  assign bus.out_rd         = rd_reg;
  assign bus.out_reg_write  = reg_write_reg && valid_int;
  assign bus.out_mem_read   = mem_read_reg  && valid_int;
  assign bus.out_mem_write  = mem_write_reg && valid_int;
  assign bus.out_funct3     = funct3_reg;
  assign bus.redirect_valid = redirect_valid_reg;
  assign bus.redirect_pc    = redirect_pc_reg;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, taken/not-taken branches, JAL/JALR
// targets, stall hold, flush priority and asynchronous reset mid-operation.
module tb_ex_mem_stage;

`ifdef EX_MEM_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ex_mem_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  ex_mem_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_valid     = 1'b0;
    bus.alu_out      = '0;
    bus.branch_taken = 1'b0;
    bus.is_branch    = 1'b0;
    bus.is_jal       = 1'b0;
    bus.is_jalr      = 1'b0;
    bus.pc           = '0;
    bus.imm          = '0;
    bus.rs1_data     = '0;
    bus.rs2_data     = '0;
    bus.rd           = '0;
    bus.reg_write    = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.funct3       = 3'd0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear_inputs();
    bus.mem_stall = 1'b0;
    bus.flush     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_redirect_valid", bus.redirect_valid, 0);
    check("rst_out_result", bus.out_result, 0);
    rst = 1'b0;
    tick();
    check("idle_out_valid", bus.out_valid, 0);

    // Taken BEQ: target pc+imm, reg_write forced low
    bus.in_valid = 1'b1; bus.is_branch = 1'b1; bus.branch_taken = 1'b1;
    bus.pc = 32'h100; bus.imm = 32'h20; bus.alu_out = 32'h55; bus.reg_write = 1'b1; bus.rd = 5'd3;
    tick();
    check("beq_out_valid", bus.out_valid, 1);
    check("beq_redirect_valid", bus.redirect_valid, 1);
    check("beq_redirect_pc", bus.redirect_pc, 32'h120);
    check("beq_out_reg_write", bus.out_reg_write, 0);
    clear_inputs();
    tick();
    check("beq_redirect_once", bus.redirect_valid, 0);
    check("drain_out_valid", bus.out_valid, 0);

    // JALR: (rs1+imm) with bit 0 cleared, link value passes through
    bus.in_valid = 1'b1; bus.is_jalr = 1'b1; bus.rs1_data = 32'h2003; bus.imm = 32'h4;
    bus.alu_out = 32'h104; bus.reg_write = 1'b1; bus.rd = 5'd1;
    tick();
    check("jalr_redirect_valid", bus.redirect_valid, MIS_EN ? 0 : 1);
    check("jalr_redirect_pc", bus.redirect_pc, MIS_EN ? 32'h0 : 32'h2006);
    check("jalr_out_result", bus.out_result, 32'h104);
    check("jalr_out_reg_write", bus.out_reg_write, 1);
    check("jalr_out_rd", bus.out_rd, 1);

    // JAL back-to-back with wrap-around target
    clear_inputs();
    bus.in_valid = 1'b1; bus.is_jal = 1'b1; bus.pc = 32'hFFFF_FFF0; bus.imm = 32'h20; bus.alu_out = 32'hFFFF_FFF4;
    tick();
    check("jal_wrap_redirect_valid", bus.redirect_valid, 1);
    check("jal_wrap_redirect_pc", bus.redirect_pc, 32'h10);
    check("jal_out_result", bus.out_result, 32'hFFFF_FFF4);

    // Not-taken branch: valid, no redirect
    clear_inputs();
    bus.in_valid = 1'b1; bus.is_branch = 1'b1; bus.branch_taken = 1'b0; bus.pc = 32'h300; bus.imm = 32'h40;
    tick();
    check("bnt_out_valid", bus.out_valid, 1);
    check("bnt_redirect_valid", bus.redirect_valid, 0);

    // Stall hold: capture JAL with alu_out=0xAA, then stall 3 cycles
    clear_inputs();
    bus.in_valid = 1'b1; bus.is_jal = 1'b1; bus.pc = 32'h200; bus.imm = 32'h10; bus.alu_out = 32'hAA;
    bus.reg_write = 1'b1; bus.rd = 5'd5;
    tick();
    check("hold_cap_result", bus.out_result, 32'hAA);
    check("hold_cap_redirect_pc", bus.redirect_pc, 32'h210);
    bus.mem_stall = 1'b1;
    bus.alu_out = 32'hBB; bus.pc = 32'h400; bus.rd = 5'd7;
    #1;
    check("hold_in_ready", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_out_result", bus.out_result, 32'hAA);
      check("hold_out_rd", bus.out_rd, 5);
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_redirect_valid", bus.redirect_valid, 0);
      check("hold_in_ready_cyc", bus.in_ready, 0);
    end
    bus.is_jal = 1'b0;
    bus.mem_stall = 1'b0;
    #1;
    check("unstall_in_ready", bus.in_ready, 1);
    tick();
    check("unstall_out_result", bus.out_result, 32'hBB);
    check("unstall_out_rd", bus.out_rd, 7);
    check("unstall_redirect_valid", bus.redirect_valid, 0);

    // Flush + stall + capture attempt: flush wins, fields retained
    clear_inputs();
    bus.in_valid = 1'b1; bus.is_jal = 1'b1; bus.pc = 32'h500; bus.imm = 32'h8; bus.alu_out = 32'hCC;
    bus.flush = 1'b1; bus.mem_stall = 1'b1;
    tick();
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_redirect_valid", bus.redirect_valid, 0);
    check("flush_out_result_kept", bus.out_result, 32'hBB);
    check("flush_out_reg_write", bus.out_reg_write, 0);
    bus.flush = 1'b0; bus.mem_stall = 1'b0;
    clear_inputs();

    // Aligned word store
    bus.in_valid = 1'b1; bus.mem_write = 1'b1; bus.funct3 = 3'd2; bus.alu_out = 32'h1000; bus.rs2_data = 32'hDEAD_BEEF;
    tick();
    check("st_out_mem_write", bus.out_mem_write, 1);
    check("st_out_store_data", bus.out_store_data, 32'hDEAD_BEEF);
    check("st_out_funct3", bus.out_funct3, 2);

    // Misaligned word store
    bus.alu_out = 32'h1002;
    tick();
    check("mis_st_out_mem_write", bus.out_mem_write, MIS_EN ? 0 : 1);
`ifdef EX_MEM_MISALIGN_EN
    check("mis_st_exc_valid", bus.exc_valid, 1);
    check("mis_st_exc_cause", bus.exc_cause, 2);
`endif

    // Reset mid-operation: clears without a clock edge
    clear_inputs();
    bus.in_valid = 1'b1; bus.alu_out = 32'h1234; bus.reg_write = 1'b1; bus.rd = 5'd9;
    tick();
    check("pre_rst_out_result", bus.out_result, 32'h1234);
    bus.in_valid = 1'b1; bus.is_jal = 1'b1; bus.pc = 32'h40;
    tick();
    check("pre_rst_redirect_valid", bus.redirect_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_result", bus.out_result, 0);
    check("async_rst_out_valid", bus.out_valid, 0);
    check("async_rst_out_rd", bus.out_rd, 0);
    check("async_rst_redirect_valid", bus.redirect_valid, 0);
    check("async_rst_redirect_pc", bus.redirect_pc, 0);
    check("async_rst_in_ready", bus.in_ready, 1);
    clear_inputs();
    tick();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
